// File: rtl/mem_req_bridge_pkg.sv
// Shared types and constants for the cpu-to-data-memory request bridge.
package mem_req_bridge_pkg;

    localparam int unsigned DefaultAddrWidth = 32;
    localparam int unsigned DefaultDataWidth = 32;

    // Clears the byte offset so the memory always sees a word address.
    localparam logic [63:0] WordAlignMask = ~64'h3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/mem_req_bridge_if.sv
// Request/response handshake and memory-side signals of the bridge.
interface mem_req_bridge_if
    import mem_req_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
);

    localparam int unsigned MaskWidth = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [MaskWidth-1:0]  req_wmask;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;

    logic                  mem_en;
    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [MaskWidth-1:0]  mem_wmask;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Bridge view.
    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata,
        output mem_en, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

    // Cpu plus memory view.
    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_en, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a flag that marks the final wait cycle.
module mem_lat_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign last = (count_q == CNT_W'(1));

endmodule

// File: rtl/mem_req_bridge.sv
// Registers a single-cycle cpu memory access into a valid/ready transaction
// with a fixed wait latency and exactly one memory-enable cycle per request.
module mem_req_bridge
    import mem_req_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned CNT_W      = 4
) (
    input logic              clk,
    input logic              rst,
    mem_req_bridge_if.slave  bus
);

    localparam int unsigned          MaskWidth  = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0]     LatLoad    = CNT_W'(LATENCY);
    localparam logic [ADDR_WIDTH-1:0] AlignMask = WordAlignMask[ADDR_WIDTH-1:0];

    bridge_state_e state_q, state_d;

    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MaskWidth-1:0]  wmask_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic accept;
    logic cnt_dec;
    logic cnt_last;

    mem_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (LatLoad),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        cnt_dec        = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_wen    = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_wmask  = '0;

        unique case (state_q)
            StIdle: begin
                // Gated by rst so nothing looks acceptable while held in reset.
                bus.req_ready = rst;
                if (bus.req_valid && rst) begin
                    accept  = 1'b1;
                    state_d = (LATENCY == 0) ? StAccess : StWait;
                end
            end
            StWait: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                bus.mem_en    = 1'b1;
                bus.mem_wen   = wen_q;
                bus.mem_addr  = addr_q & AlignMask;
                bus.mem_wdata = wdata_q;
                bus.mem_wmask = wen_q ? wmask_q : '0;
                state_d       = StResp;
            end
            StResp: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wen_q   <= bus.req_wen;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                wmask_q <= bus.req_wmask;
            end
            if (state_q == StAccess) begin
                rdata_q <= wen_q ? '0 : bus.mem_rdata;
            end
        end
    end

    assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_req_bridge.sv
// Bench for mem_req_bridge: three instances with LATENCY 0, 2 and 4 checked
// against a cycle-timeline model of each transaction.
module tb_mem_req_bridge;

    localparam int unsigned NDut = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        req_valid  [NDut];
    logic        req_wen    [NDut];
    logic [31:0] req_addr   [NDut];
    logic [31:0] req_wdata  [NDut];
    logic [3:0]  req_wmask  [NDut];
    logic        resp_ready [NDut];
    logic [31:0] mem_rdata  [NDut];

    logic        req_ready  [NDut];
    logic        resp_valid [NDut];
    logic [31:0] resp_rdata [NDut];
    logic        mem_en     [NDut];
    logic        mem_wen    [NDut];
    logic [31:0] mem_addr   [NDut];
    logic [31:0] mem_wdata  [NDut];
    logic [3:0]  mem_wmask  [NDut];

    for (genvar g = 0; g < NDut; g++) begin : g_dut
        mem_req_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
        assign bus.req_valid  = req_valid[g];
        assign bus.req_wen    = req_wen[g];
        assign bus.req_addr   = req_addr[g];
        assign bus.req_wdata  = req_wdata[g];
        assign bus.req_wmask  = req_wmask[g];
        assign bus.resp_ready = resp_ready[g];
        assign bus.mem_rdata  = mem_rdata[g];
        assign req_ready[g]   = bus.req_ready;
        assign resp_valid[g]  = bus.resp_valid;
        assign resp_rdata[g]  = bus.resp_rdata;
        assign mem_en[g]      = bus.mem_en;
        assign mem_wen[g]     = bus.mem_wen;
        assign mem_addr[g]    = bus.mem_addr;
        assign mem_wdata[g]   = bus.mem_wdata;
        assign mem_wmask[g]   = bus.mem_wmask;

        mem_req_bridge #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .LATENCY    (2 * g),
            .CNT_W      (4)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observations of the latest transaction.
    int          o_en_cnt, o_en_cyc, o_resp_cyc, o_wait;
    logic        o_wen, o_timeout, o_idle_bad, o_stall_bad;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_wmask;

    function automatic int lat_of(input int d);
        return 2 * d;
    endfunction

    // Issue one request on instance d and record what happens up to the
    // handshake cycle; inputs are scrambled after the accept edge.
    task automatic do_txn(input int d, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          input logic [31:0] rdata, input int stall, input logic hold);
        int lat;
        int waitc;
        lat = lat_of(d);
        o_en_cnt = 0; o_en_cyc = -1; o_resp_cyc = -1; o_wait = 0;
        o_wen = 1'b0; o_addr = '0; o_wdata = '0; o_wmask = '0; o_rdata = '0;
        o_timeout = 1'b0; o_idle_bad = 1'b0; o_stall_bad = 1'b0;
        @(negedge clk);
        req_wen[d] = wen; req_addr[d] = addr; req_wdata[d] = wdata; req_wmask[d] = wmask;
        mem_rdata[d] = rdata; req_valid[d] = 1'b1; resp_ready[d] = (stall == 0);
        waitc = 0;
        while (req_ready[d] !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        o_wait = waitc;
        if (waitc >= 20) begin
            o_timeout = 1'b1;
            req_valid[d] = 1'b0;
            return;
        end
        for (int k = 1; k <= lat + 2 + stall; k++) begin
            @(negedge clk);
            if (mem_en[d] === 1'b1) begin
                o_en_cnt++; o_en_cyc = k; o_wen = mem_wen[d]; o_addr = mem_addr[d];
                o_wdata = mem_wdata[d]; o_wmask = mem_wmask[d];
            end else if (mem_wen[d] !== 1'b0 || mem_addr[d] !== 0 || mem_wdata[d] !== 0
                         || mem_wmask[d] !== 0) begin
                o_idle_bad = 1'b1;
            end
            if (req_ready[d] !== 1'b0) o_idle_bad = 1'b1;
            if (resp_valid[d] === 1'b1) begin
                if (o_resp_cyc < 0) begin
                    o_resp_cyc = k;
                    o_rdata = resp_rdata[d];
                end else if (resp_rdata[d] !== o_rdata) begin
                    o_stall_bad = 1'b1;
                end
            end else if (o_resp_cyc >= 0) begin
                o_stall_bad = 1'b1;
            end
            if (k == 1) begin
                req_wen[d] = ~wen; req_addr[d] = $urandom; req_wdata[d] = $urandom;
                req_wmask[d] = 4'($urandom);
                if (!hold) req_valid[d] = 1'b0;
            end
            if (k == lat + 2 + stall) resp_ready[d] = 1'b1;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < NDut; d++) begin
            req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
            req_wmask[d] = '0; resp_ready[d] = 1'b1; mem_rdata[d] = '0;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDut; d++) begin
            checks++;
            if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 0) begin
                errors++;
                $display("FAIL reset_resp[%0d]: ready=%b valid=%b rdata=%h want 0 0 0", d,
                         req_ready[d], resp_valid[d], resp_rdata[d]);
            end
            checks++;
            if (mem_en[d] !== 1'b0 || mem_wen[d] !== 1'b0 || mem_addr[d] !== 0
                || mem_wdata[d] !== 0 || mem_wmask[d] !== 0) begin
                errors++;
                $display("FAIL reset_mem[%0d]: en=%b addr=%h want all zero", d, mem_en[d],
                         mem_addr[d]);
            end
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < NDut; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release_ready[%0d]: got %b want 1", d, req_ready[d]);
            end
        end
    endtask

    task automatic test_read_lat2();
        do_txn(1, 1'b0, 32'h8000_0004, 32'h5555_AAAA, 4'hF, 32'hDEAD_BEEF, 0, 1'b0);
        checks++;
        if (o_timeout !== 1'b0 || o_wait !== 0) begin
            errors++; $display("FAIL rd2_accept: waited %0d want 0", o_wait);
        end
        checks++;
        if (o_en_cnt !== 1 || o_en_cyc !== 3) begin
            errors++;
            $display("FAIL rd2_mem_en: pulses=%0d cycle=%0d want 1 at 3", o_en_cnt, o_en_cyc);
        end
        checks++;
        if (o_addr !== 32'h8000_0004 || o_wen !== 1'b0 || o_wmask !== 4'h0) begin
            errors++;
            $display("FAIL rd2_mem_fields: addr=%h wen=%b mask=%h want 80000004 0 0",
                     o_addr, o_wen, o_wmask);
        end
        checks++;
        if (o_resp_cyc !== 4 || o_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd2_resp: cycle=%0d rdata=%h want 4 deadbeef", o_resp_cyc, o_rdata);
        end
        checks++;
        if (o_idle_bad !== 1'b0) begin
            errors++; $display("FAIL rd2_idle_outputs: got %b want 0", o_idle_bad);
        end
        @(negedge clk);
        checks++;
        if (req_ready[1] !== 1'b1) begin
            errors++; $display("FAIL rd2_ready_cycle5: got %b want 1", req_ready[1]);
        end
    endtask

    task automatic test_write();
        do_txn(1, 1'b1, 32'h8000_0012, 32'h1122_3344, 4'b1100, 32'hFFFF_0000, 0, 1'b0);
        checks++;
        if (o_en_cnt !== 1 || o_wen !== 1'b1 || o_addr !== 32'h8000_0010) begin
            errors++;
            $display("FAIL wr_mem: pulses=%0d wen=%b addr=%h want 1 1 80000010", o_en_cnt,
                     o_wen, o_addr);
        end
        checks++;
        if (o_wmask !== 4'b1100 || o_wdata !== 32'h1122_3344) begin
            errors++;
            $display("FAIL wr_data: mask=%b wdata=%h want 1100 11223344", o_wmask, o_wdata);
        end
        checks++;
        if (o_resp_cyc !== 4 || o_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wr_resp: cycle=%0d rdata=%h want 4 0", o_resp_cyc, o_rdata);
        end
    endtask

    task automatic test_backpressure();
        do_txn(1, 1'b0, 32'h0000_2008, 32'h0, 4'h0, 32'h0BAD_F00D, 5, 1'b1);
        checks++;
        if (o_stall_bad !== 1'b0 || o_idle_bad !== 1'b0 || o_en_cnt !== 1) begin
            errors++;
            $display("FAIL bp_stable: stall_bad=%b idle_bad=%b pulses=%0d want 0 0 1",
                     o_stall_bad, o_idle_bad, o_en_cnt);
        end
        checks++;
        if (o_resp_cyc !== 4 || o_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL bp_resp: cycle=%0d rdata=%h want 4 0badf00d", o_resp_cyc, o_rdata);
        end
        do_txn(1, 1'b0, 32'h0000_200C, 32'h0, 4'h0, 32'h1357_9BDF, 0, 1'b0);
        checks++;
        if (o_wait !== 0 || o_rdata !== 32'h1357_9BDF || o_addr !== 32'h0000_200C) begin
            errors++;
            $display("FAIL bp_next: wait=%0d rdata=%h addr=%h want 0 13579bdf 0000200c",
                     o_wait, o_rdata, o_addr);
        end
    endtask

    task automatic test_reset_mid_op();
        int bad;
        @(negedge clk);
        req_wen[2] = 1'b0; req_addr[2] = 32'h0000_0040; mem_rdata[2] = 32'h7777_7777;
        req_valid[2] = 1'b1; resp_ready[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (req_ready[2] !== 1'b0 || mem_en[2] !== 1'b0 || resp_valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_clear: ready=%b en=%b valid=%b want 0 0 0", req_ready[2],
                     mem_en[2], resp_valid[2]);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready[2] !== 1'b1) begin
            errors++; $display("FAIL rstwait_ready: got %b want 1", req_ready[2]);
        end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (mem_en[2] !== 1'b0 || resp_valid[2] !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL rstwait_no_access: bad cycles=%0d want 0", bad);
        end
        // Pending response dropped by reset during RESP (LATENCY 0).
        @(negedge clk);
        req_wen[0] = 1'b0; req_addr[0] = 32'h0000_0080; mem_rdata[0] = 32'h2468_ACE0;
        req_valid[0] = 1'b1; resp_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'h2468_ACE0) begin
            errors++;
            $display("FAIL rstresp_pending: valid=%b rdata=%h want 1 2468ace0", resp_valid[0],
                     resp_rdata[0]);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 0) begin
            errors++;
            $display("FAIL rstresp_drop: valid=%b rdata=%h want 0 0", resp_valid[0],
                     resp_rdata[0]);
        end
        @(negedge clk);
        rst = 1'b1; resp_ready[0] = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL rstresp_idle: bad cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_lat0();
        do_txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 1'b0);
        checks++;
        if (o_en_cnt !== 1 || o_en_cyc !== 1 || o_addr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL lat0_mem_en: pulses=%0d cycle=%0d addr=%h want 1 1 80000000",
                     o_en_cnt, o_en_cyc, o_addr);
        end
        checks++;
        if (o_resp_cyc !== 2 || o_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL lat0_resp: cycle=%0d rdata=%h want 2 cafef00d", o_resp_cyc, o_rdata);
        end
    endtask

    task automatic test_back_to_back();
        do_txn(1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hA1A1_0100, 0, 1'b1);
        checks++;
        if (o_en_cnt !== 1 || o_addr !== 32'h100 || o_rdata !== 32'hA1A1_0100) begin
            errors++;
            $display("FAIL b2b_first: pulses=%0d addr=%h rdata=%h want 1 100 a1a10100",
                     o_en_cnt, o_addr, o_rdata);
        end
        do_txn(1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'hB2B2_0104, 0, 1'b0);
        checks++;
        if (o_wait !== 0 || o_en_cnt !== 1 || o_en_cyc !== 3) begin
            errors++;
            $display("FAIL b2b_spacing: wait=%0d pulses=%0d cycle=%0d want 0 1 3", o_wait,
                     o_en_cnt, o_en_cyc);
        end
        checks++;
        if (o_addr !== 32'h104 || o_rdata !== 32'hB2B2_0104) begin
            errors++;
            $display("FAIL b2b_second: addr=%h rdata=%h want 104 b2b20104", o_addr, o_rdata);
        end
    endtask

    task automatic test_random();
        int d, stall, lat;
        logic wen;
        logic [31:0] addr, wdata, rdata, e_addr, e_rdata;
        logic [3:0] wmask, e_mask;
        for (int i = 0; i < 24; i++) begin
            d = $urandom_range(0, NDut - 1);
            lat = lat_of(d);
            wen = 1'($urandom); addr = $urandom; wdata = $urandom; rdata = $urandom;
            wmask = 4'($urandom); stall = $urandom_range(0, 3);
            e_addr = {addr[31:2], 2'b00};
            e_mask = wen ? wmask : 4'h0;
            e_rdata = wen ? 32'h0 : rdata;
            do_txn(d, wen, addr, wdata, wmask, rdata, stall, 1'b0);
            checks++;
            if (o_timeout !== 1'b0 || o_en_cnt !== 1 || o_en_cyc !== lat + 1) begin
                errors++;
                $display("FAIL rnd%0d_en: to=%b pulses=%0d cycle=%0d want 0 1 %0d", i,
                         o_timeout, o_en_cnt, o_en_cyc, lat + 1);
            end
            checks++;
            if (o_wen !== wen || o_addr !== e_addr || o_wdata !== wdata || o_wmask !== e_mask)
            begin
                errors++;
                $display("FAIL rnd%0d_mem: %b %h %h %h want %b %h %h %h", i, o_wen, o_addr,
                         o_wdata, o_wmask, wen, e_addr, wdata, e_mask);
            end
            checks++;
            if (o_resp_cyc !== lat + 2 || o_rdata !== e_rdata) begin
                errors++;
                $display("FAIL rnd%0d_resp: cycle=%0d rdata=%h want %0d %h", i, o_resp_cyc,
                         o_rdata, lat + 2, e_rdata);
            end
            checks++;
            if (o_idle_bad !== 1'b0 || o_stall_bad !== 1'b0) begin
                errors++;
                $display("FAIL rnd%0d_protocol: idle_bad=%b stall_bad=%b want 0 0", i,
                         o_idle_bad, o_stall_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_lat2();
        test_write();
        test_backpressure();
        test_reset_mid_op();
        test_lat0();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
